// File: rtl/lcd_write_sequencer.sv
// HD44780 8-bit write sequencer: power-on init ROM, then application writes
// turned into timed RS/E/DB bus cycles, each followed by the execution delay.
module lcd_write_sequencer #(
  parameter int unsigned CLK_FREQ  = 125_000_000,
  parameter int unsigned AS_CYC    = 32'((64'd60       * 64'(CLK_FREQ) + 64'd999_999_999) / 64'd1_000_000_000),
  parameter int unsigned PW_CYC    = 32'((64'd450      * 64'(CLK_FREQ) + 64'd999_999_999) / 64'd1_000_000_000),
  parameter int unsigned HOLD_CYC  = 32'((64'd20       * 64'(CLK_FREQ) + 64'd999_999_999) / 64'd1_000_000_000),
  parameter int unsigned EXEC_CYC  = 32'((64'd40000    * 64'(CLK_FREQ) + 64'd999_999_999) / 64'd1_000_000_000),
  parameter int unsigned CLEAR_CYC = 32'((64'd1640000  * 64'(CLK_FREQ) + 64'd999_999_999) / 64'd1_000_000_000),
  parameter int unsigned PWRUP_CYC = 32'((64'd15000000 * 64'(CLK_FREQ) + 64'd999_999_999) / 64'd1_000_000_000),
  parameter int unsigned INIT1_CYC = 32'((64'd4100000  * 64'(CLK_FREQ) + 64'd999_999_999) / 64'd1_000_000_000),
  parameter int unsigned INIT2_CYC = 32'((64'd100000   * 64'(CLK_FREQ) + 64'd999_999_999) / 64'd1_000_000_000)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_valid_i,
  input  logic       wr_rs_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  output logic       init_done_o,
  output logic       busy_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_db_o,
  output logic [2:0] dbg_state_o
);

  // A zero-length phase is stretched to one cycle.
  localparam int unsigned AS_L    = (AS_CYC    == 0) ? 1 : AS_CYC;
  localparam int unsigned PW_L    = (PW_CYC    == 0) ? 1 : PW_CYC;
  localparam int unsigned HOLD_L  = (HOLD_CYC  == 0) ? 1 : HOLD_CYC;
  localparam int unsigned EXEC_L  = (EXEC_CYC  == 0) ? 1 : EXEC_CYC;
  localparam int unsigned CLEAR_L = (CLEAR_CYC == 0) ? 1 : CLEAR_CYC;
  localparam int unsigned PWRUP_L = (PWRUP_CYC == 0) ? 1 : PWRUP_CYC;
  localparam int unsigned INIT1_L = (INIT1_CYC == 0) ? 1 : INIT1_CYC;
  localparam int unsigned INIT2_L = (INIT2_CYC == 0) ? 1 : INIT2_CYC;

  localparam int unsigned M0 = (AS_L > PW_L) ? AS_L : PW_L;
  localparam int unsigned M1 = (M0 > HOLD_L) ? M0 : HOLD_L;
  localparam int unsigned M2 = (M1 > EXEC_L) ? M1 : EXEC_L;
  localparam int unsigned M3 = (M2 > CLEAR_L) ? M2 : CLEAR_L;
  localparam int unsigned M4 = (M3 > PWRUP_L) ? M3 : PWRUP_L;
  localparam int unsigned M5 = (M4 > INIT1_L) ? M4 : INIT1_L;
  localparam int unsigned MAX_L = (M5 > INIT2_L) ? M5 : INIT2_L;
  localparam int CW = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  localparam logic [CW-1:0] AS_LD    = CW'(AS_L - 1);
  localparam logic [CW-1:0] PW_LD    = CW'(PW_L - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_L - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_L - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_L - 1);
  localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_L - 1);
  localparam logic [CW-1:0] INIT1_LD = CW'(INIT1_L - 1);
  localparam logic [CW-1:0] INIT2_LD = CW'(INIT2_L - 1);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_IDLE  = 3'd5
  } state_t;

  function automatic logic [7:0] rom_db(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: rom_db = 8'h30;
      3'd3:             rom_db = 8'h38;
      3'd4:             rom_db = 8'h08;
      3'd5:             rom_db = 8'h01;
      3'd6:             rom_db = 8'h06;
      default:          rom_db = 8'h0C;
    endcase
  endfunction

  function automatic logic [CW-1:0] rom_wait(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_wait = INIT1_LD;
      3'd1:    rom_wait = INIT2_LD;
      3'd5:    rom_wait = CLEAR_LD;
      default: rom_wait = EXEC_LD;
    endcase
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_delay;
  logic [2:0]    r_idx;
  logic          r_init_done;
  logic          r_ready;
  logic          r_busy;
  logic          r_e;
  logic          r_rs;
  logic [7:0]    r_db;

  // Handshake: a write transfers on a rising edge where wr_valid_i and
  // wr_ready_o are both 1; ready is only high in IDLE after init and drops
  // the cycle after the transfer until the post-write wait has expired.
  // Requests seen while ready is low are not stored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_PWRUP;
      r_cnt       <= PWRUP_LD;
      r_delay     <= '0;
      r_idx       <= 3'd0;
      r_init_done <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
      r_e         <= 1'b0;
      r_rs        <= 1'b0;
      r_db        <= 8'h00;
    end else if (r_state != S_IDLE && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end else begin
      case (r_state)
        S_PWRUP: begin
          r_state <= S_SETUP;
          r_cnt   <= AS_LD;
          r_idx   <= 3'd0;
          r_rs    <= 1'b0;
          r_db    <= rom_db(3'd0);
          r_delay <= rom_wait(3'd0);
        end
        S_SETUP: begin
          r_state <= S_PULSE;
          r_cnt   <= PW_LD;
          r_e     <= 1'b1;
        end
        S_PULSE: begin
          r_state <= S_HOLD;
          r_cnt   <= HOLD_LD;
          r_e     <= 1'b0;
        end
        S_HOLD: begin
          r_state <= S_WAIT;
          r_cnt   <= r_delay;
        end
        S_WAIT: begin
          if (!r_init_done && r_idx != 3'd7) begin
            r_state <= S_SETUP;
            r_cnt   <= AS_LD;
            r_idx   <= r_idx + 3'd1;
            r_db    <= rom_db(r_idx + 3'd1);
            r_delay <= rom_wait(r_idx + 3'd1);
          end else begin
            r_state     <= S_IDLE;
            r_init_done <= 1'b1;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_IDLE: begin
          if (wr_valid_i && r_ready) begin
            r_state <= S_SETUP;
            r_cnt   <= AS_LD;
            r_rs    <= wr_rs_i;
            r_db    <= wr_data_i;
            // Clear display and return home need the long execution time.
            r_delay <= (!wr_rs_i && wr_data_i[7:2] == 6'd0) ? CLEAR_LD : EXEC_LD;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_PWRUP;
          r_cnt   <= PWRUP_LD;
        end
      endcase
    end
  end

  assign wr_ready_o  = r_ready;
  assign init_done_o = r_init_done;
  assign busy_o      = r_busy;
  assign lcd_rs_o    = r_rs;
  assign lcd_rw_o    = 1'b0;
  assign lcd_e_o     = r_e;
  assign lcd_db_o    = r_db;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: a timing model predicts every E pulse and the
// ready window of each write; a second instance runs with zero bus-phase lengths.
module tb_lcd_write_sequencer;

  localparam int AS = 2, PW = 3, HOLD = 1, EXEC = 5, CLEAR = 20;
  localparam int PWRUP = 10, INIT1 = 8, INIT2 = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       wr_valid_i = 1'b0;
  logic       wr_rs_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       wr_ready_o, init_done_o, busy_o, lcd_rs_o, lcd_rw_o, lcd_e_o;
  logic [7:0] lcd_db_o;
  logic [2:0] dbg_state;
  logic       z_ready, z_done, z_busy, z_rs, z_rw, z_e;
  logic [7:0] z_db;
  logic [2:0] z_dbg;

  always #5 clk_i = ~clk_i;

  lcd_write_sequencer #(
    .AS_CYC(AS), .PW_CYC(PW), .HOLD_CYC(HOLD), .EXEC_CYC(EXEC), .CLEAR_CYC(CLEAR),
    .PWRUP_CYC(PWRUP), .INIT1_CYC(INIT1), .INIT2_CYC(INIT2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_valid_i(wr_valid_i), .wr_rs_i(wr_rs_i),
    .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o), .init_done_o(init_done_o),
    .busy_o(busy_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_e_o(lcd_e_o),
    .lcd_db_o(lcd_db_o), .dbg_state_o(dbg_state)
  );

  lcd_write_sequencer #(
    .AS_CYC(0), .PW_CYC(0), .HOLD_CYC(0), .EXEC_CYC(EXEC), .CLEAR_CYC(CLEAR),
    .PWRUP_CYC(PWRUP), .INIT1_CYC(INIT1), .INIT2_CYC(INIT2)
  ) dut_z (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_valid_i(1'b0), .wr_rs_i(1'b0),
    .wr_data_i(8'h00), .wr_ready_o(z_ready), .init_done_o(z_done),
    .busy_o(z_busy), .lcd_rs_o(z_rs), .lcd_rw_o(z_rw), .lcd_e_o(z_e),
    .lcd_db_o(z_db), .dbg_state_o(z_dbg)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_after, init_end, init_end_z, rise_c, rise_cz;
  logic [7:0] rise_db;
  logic prev_e, prev_ez;
  logic [40:0] exp_q[$];  // {rise cycle, rs, db}
  int zq[$];
  logic [7:0] rom_db [8];
  int rom_w [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_e"}, 32'(lcd_e_o), 0);
    chk({tag, "_rs"}, 32'(lcd_rs_o), 0);
    chk({tag, "_rw"}, 32'(lcd_rw_o), 0);
    chk({tag, "_db"}, 32'(lcd_db_o), 0);
    chk({tag, "_ready"}, 32'(wr_ready_o), 0);
    chk({tag, "_done"}, 32'(init_done_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 1);
    chk({tag, "_z_e"}, 32'(z_e), 0);
    chk({tag, "_z_busy"}, 32'(z_busy), 1);
  endtask

  // Timeline after reset release: cyc = n at the negedge following edge n.
  task automatic start_init();
    int t, tz;
    cyc = 0;
    prev_e = 1'b0;
    prev_ez = 1'b0;
    exp_q.delete();
    zq.delete();
    t = PWRUP;
    tz = PWRUP;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({32'(t + AS), 1'b0, rom_db[i]});
      t += AS + PW + HOLD + rom_w[i];
      zq.push_back(tz + 1);
      tz += 3 + rom_w[i];
    end
    ready_after = t;
    init_end = t;
    init_end_z = tz;
  endtask

  task automatic tick();
    logic [40:0] e;
    @(negedge clk_i);
    cyc++;
    chk("ready", 32'(wr_ready_o), 32'(cyc >= ready_after));
    chk("busy", 32'(busy_o), 32'(cyc < ready_after));
    chk("init_done", 32'(init_done_o), 32'(cyc >= init_end));
    chk("rw", 32'(lcd_rw_o), 0);
    if (lcd_e_o && !prev_e) begin
      chk("pulse_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("e_rise", 32'(cyc), e[40:9]);
        chk("e_rs", 32'(lcd_rs_o), 32'(e[8]));
        chk("e_db", 32'(lcd_db_o), 32'(e[7:0]));
      end
      rise_c = cyc;
      rise_db = lcd_db_o;
    end
    if (!lcd_e_o && prev_e) begin
      chk("e_width", 32'(cyc - rise_c), PW);
      chk("db_stable", 32'(lcd_db_o), 32'(rise_db));
    end
    prev_e = lcd_e_o;
    chk("z_ready", 32'(z_ready), 32'(cyc >= init_end_z));
    chk("z_done", 32'(z_done), 32'(cyc >= init_end_z));
    if (z_e && !prev_ez) begin
      chk("z_pulse_pending", 32'(zq.size() > 0), 1);
      if (zq.size() > 0) chk("z_rise", 32'(cyc), 32'(zq.pop_front()));
      rise_cz = cyc;
    end
    if (!z_e && prev_ez) chk("z_e_width", 32'(cyc - rise_cz), 1);
    prev_ez = z_e;
  endtask

  task automatic drive(input logic v, input logic rs, input logic [7:0] d, output logic acc);
    int k;
    wr_valid_i = v;
    wr_rs_i = rs;
    wr_data_i = d;
    acc = v && (cyc >= ready_after);
    if (acc) begin
      k = cyc + 1;
      exp_q.push_back({32'(k + AS), rs, d});
      ready_after = k + AS + PW + HOLD + ((!rs && d < 8'd4) ? CLEAR : EXEC);
    end
    tick();
    if (acc) begin
      chk("acc_db", 32'(lcd_db_o), 32'(d));
      chk("acc_rs", 32'(lcd_rs_o), 32'(rs));
    end
  endtask

  task automatic idle_until_ready(input int bound);
    logic a;
    int n;
    n = 0;
    while (cyc < ready_after && n < bound) begin
      drive(1'b0, 1'b0, 8'h00, a);
      n++;
    end
    drive(1'b0, 1'b0, 8'h00, a);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    logic a;
    int n;
    n = 0;
    do begin
      drive(1'b1, rs, d, a);
      n++;
    end while (!a && n < 400);
  endtask

  initial begin
    logic a;
    logic v, rs;
    logic [7:0] d;
    rom_db = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    rom_w = '{INIT1, INIT2, EXEC, EXEC, EXEC, CLEAR, EXEC, EXEC};

    #2 rst_ni = 1'b0;
    #1 check_reset("por");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    start_init();
    idle_until_ready(300);

    send(1'b1, 8'h48);
    idle_until_ready(100);
    send(1'b0, 8'h01);
    idle_until_ready(100);
    send(1'b0, 8'h02);
    idle_until_ready(100);
    send(1'b0, 8'h80);
    idle_until_ready(100);

    // Valid mostly held high with data changing every cycle.
    repeat (400) begin
      v = ($urandom_range(0, 3) != 0);
      rs = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      drive(v, rs, d, a);
    end
    idle_until_ready(100);
    chk("queue_drained", 32'(exp_q.size()), 0);

    send(1'b1, 8'h55);
    for (int i = 0; i < 20 && !lcd_e_o; i++) drive(1'b0, 1'b0, 8'h00, a);
    chk("e_seen_before_reset", 32'(lcd_e_o), 1);
    #2 rst_ni = 1'b0;
    #1 check_reset("mid");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    start_init();
    idle_until_ready(300);
    send(1'b1, 8'h21);
    idle_until_ready(100);
    chk("final_queue", 32'(exp_q.size()), 0);
    chk("final_z_queue", 32'(zq.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
